// File: rtl/fifo_rd_arbiter.sv
// Read-side scheduler for the dual-clock FIFO: round-robin burst grants, FIFO read strobe and
// owner-tagged response routing. Optional macro FIFO_RD_ARB_PRIO_EN gives requester 0 priority.
module fifo_rd_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int BURST_LEN = 4,
  parameter int DW        = 8
) (
  input  logic               rd_clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  input  logic               fifo_empty,
  output logic               fifo_rd,
  input  logic [DW-1:0]      fifo_data,
  output logic [NUM_REQ-1:0] rsp_valid,
  output logic [DW-1:0]      rsp_data,
  output logic               busy
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(BURST_LEN + 1);

  typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]      beat_cnt_q, beat_cnt_d;
  logic               p1_vld_q, p1_vld_d;
  logic [IW-1:0]      p1_owner_q, p1_owner_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]      rsp_data_q, rsp_data_d;

  logic               win_found;
  logic [IW-1:0]      win_idx;
  int                 cand;
  logic               fire;
  logic               last_beat;

  // Round-robin search starting at rr_ptr, wrapping over all requesters.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
`ifdef FIFO_RD_ARB_PRIO_EN
    if (req[0]) win_found = 1'b1;
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(rr_ptr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
`ifdef FIFO_RD_ARB_PRIO_EN
      if (!win_found && cand != 0 && req[cand]) begin
`else
      if (!win_found && req[cand]) begin
`endif
        win_found = 1'b1;
        win_idx   = cand[IW-1:0];
      end
    end
  end

  assign fire      = (state_q == GRANT) && req[owner_q] && !fifo_empty &&
                     (beat_cnt_q < CW'(BURST_LEN));
  assign last_beat = (beat_cnt_q == CW'(BURST_LEN - 1));

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (|req && !fifo_empty) begin
          owner_d    = win_idx;
          gnt_d      = NUM_REQ'(1) << win_idx;
          beat_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (fire) beat_cnt_d = beat_cnt_q + CW'(1);
        if ((fire && last_beat) || !req[owner_q] || fifo_empty) state_d = DRAIN;
      end
      DRAIN: begin
        gnt_d      = '0;
        beat_cnt_d = '0;
        state_d    = IDLE;
`ifdef FIFO_RD_ARB_PRIO_EN
        if (owner_q != '0)
`endif
        rr_ptr_d = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + IW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Response pipeline carries the owner with the data, independent of the grant FSM.
  always_comb begin
    p1_vld_d    = fire;
    p1_owner_d  = owner_q;
    rsp_valid_d = p1_vld_q ? (NUM_REQ'(1) << p1_owner_q) : '0;
    rsp_data_d  = p1_vld_q ? fifo_data : rsp_data_q;
  end

  // NOTE: all state uses non-blocking assignment so every flop samples pre-edge values;
  // the response pipeline is reset too, which is what discards an in-flight beat.
  always_ff @(posedge rd_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      p1_vld_q    <= 1'b0;
      p1_owner_q  <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      p1_vld_q    <= p1_vld_d;
      p1_owner_q  <= p1_owner_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign gnt       = gnt_q;
  assign fifo_rd   = fire;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Directed bench for fifo_rd_arbiter with a behavioural FIFO (registered data_out).
module tb_fifo_rd_arbiter;
  logic       rd_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] gnt;
  logic       fifo_empty;
  logic       fifo_rd;
  logic [7:0] fifo_data = '0;
  logic [3:0] rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 rd_clk = ~rd_clk;

  fifo_rd_arbiter #(.NUM_REQ(4), .BURST_LEN(4), .DW(8)) dut (
    .rd_clk(rd_clk), .reset_n(reset_n), .req(req), .gnt(gnt),
    .fifo_empty(fifo_empty), .fifo_rd(fifo_rd), .fifo_data(fifo_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );

  // Behavioural FIFO: data_out registered on a read fire.
  logic [7:0] mem [0:1023];
  int   wr_ptr = 0;
  int   rd_ptr = 0;
  int   cyc = 0;
  logic flush = 1'b0;
  logic rd_now = 1'b0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge rd_clk) begin
    cyc <= cyc + 1;
    if (flush) rd_ptr <= wr_ptr;
    else if (rd_now) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  logic [11:0] rsp_q [$];
  int rsp_cyc [$];
  int fire_cyc [$];
  int rd_while_empty = 0;

  always @(negedge rd_clk) begin
    rd_now = fifo_rd;
    if (fifo_rd) fire_cyc.push_back(cyc);
    if (fifo_rd && fifo_empty) rd_while_empty++;
    if (rsp_valid != '0) begin
      rsp_q.push_back({rsp_valid, rsp_data});
      rsp_cyc.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge rd_clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] v);
    mem[wr_ptr] = v;
    wr_ptr++;
  endtask

  task automatic clear_mon();
    rsp_q.delete();
    rsp_cyc.delete();
    fire_cyc.delete();
    rd_while_empty = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req     = '0;
    flush   = 1'b1;
    tick(2);
    flush   = 1'b0;
    reset_n = 1'b1;
    tick(1);
    clear_mon();
  endtask

  task automatic test_reset();
    tick(1);
    checks++;
    if ({gnt, rsp_valid, rsp_data, fifo_rd, busy} !== 18'h0) begin
      errors++;
      $display("FAIL reset_state: got gnt=%b rsp_valid=%b rsp_data=%h fifo_rd=%b busy=%b, want all 0",
               gnt, rsp_valid, rsp_data, fifo_rd, busy);
    end
    do_reset();
    for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
    req = 4'b0001;
    tick(3);  // IDLE, then two fires; first response still in flight
    reset_n = 1'b0;
    clear_mon();
    #1;
    checks++;
    if ({gnt, rsp_valid, rsp_data, fifo_rd, busy} !== 18'h0) begin
      errors++;
      $display("FAIL reset_mid_burst: got gnt=%b rsp_valid=%b rsp_data=%h fifo_rd=%b busy=%b, want all 0",
               gnt, rsp_valid, rsp_data, fifo_rd, busy);
    end
    req   = '0;
    flush = 1'b1;
    tick(2);
    flush   = 1'b0;
    reset_n = 1'b1;
    tick(6);
    checks++;
    if (rsp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_discard: got %0d responses after reset, want 0", rsp_q.size());
    end
  endtask

  task automatic test_single_burst();
    logic [11:0] exp;
    do_reset();
    for (int i = 0; i < 6; i++) push(8'hA0 + 8'(i));
    req = 4'b0010;
    tick(16);
    checks++;
    if (fire_cyc.size() != 6) begin
      errors++;
      $display("FAIL burst_fires: got %0d fires, want 6", fire_cyc.size());
    end
    checks++;
    if (rsp_q.size() != 6) begin
      errors++;
      $display("FAIL burst_rsp_count: got %0d, want 6", rsp_q.size());
    end
    for (int i = 0; i < 6 && i < rsp_q.size() && i < fire_cyc.size(); i++) begin
      exp = {4'b0010, 8'hA0 + 8'(i)};
      checks++;
      if (rsp_q[i] !== exp) begin
        errors++;
        $display("FAIL burst_rsp%0d: got %h, want %h", i, rsp_q[i], exp);
      end
      checks++;
      if (rsp_cyc[i] != fire_cyc[i] + 2) begin
        errors++;
        $display("FAIL burst_latency%0d: got %0d cycles, want 2", i, rsp_cyc[i] - fire_cyc[i]);
      end
    end
    if (fire_cyc.size() == 6) begin
      checks++;
      if (fire_cyc[3] - fire_cyc[0] != 3) begin
        errors++;
        $display("FAIL burst_back_to_back: got span %0d, want 3", fire_cyc[3] - fire_cyc[0]);
      end
      checks++;
      if (fire_cyc[4] - fire_cyc[3] != 3) begin
        errors++;
        $display("FAIL burst_turnaround: got %0d, want 3", fire_cyc[4] - fire_cyc[3]);
      end
    end
    checks++;
    if (busy !== 1'b0 || gnt !== 4'b0000) begin
      errors++;
      $display("FAIL burst_idle_after_empty: got busy=%b gnt=%b, want 0/0000", busy, gnt);
    end
    req = '0;
  endtask

  task automatic test_rr_contention();
    logic [11:0] exp;
    do_reset();
    for (int i = 0; i < 8; i++) push(8'(i));
    req = 4'b1111;
    tick(16);
    checks++;
    if (rsp_q.size() != 8) begin
      errors++;
      $display("FAIL rr_rsp_count: got %0d, want 8", rsp_q.size());
    end
    for (int i = 0; i < 8 && i < rsp_q.size(); i++) begin
      exp = {(i < 4) ? 4'b0001 : 4'b0010, 8'(i)};
      checks++;
      if (rsp_q[i] !== exp) begin
        errors++;
        $display("FAIL rr_rsp%0d: got %h, want %h", i, rsp_q[i], exp);
      end
    end
    checks++;
    if (gnt !== 4'b0000) begin
      errors++;
      $display("FAIL rr_no_grant_when_empty: got gnt=%b, want 0000", gnt);
    end
    push(8'h08);
    tick(2);
    checks++;
    if (gnt !== 4'b0100) begin
      errors++;
      $display("FAIL rr_refill_grant: got gnt=%b, want 0100", gnt);
    end
    tick(6);
    checks++;
    if (rsp_q.size() != 9 || rsp_q[rsp_q.size()-1] !== {4'b0100, 8'h08}) begin
      errors++;
      $display("FAIL rr_refill_rsp: got count %0d last %h, want 9 / 408",
               rsp_q.size(), rsp_q.size() > 0 ? rsp_q[rsp_q.size()-1] : 12'h0);
    end
    req = '0;
  endtask

  task automatic test_empty_end();
    do_reset();
    push(8'hC0);
    push(8'hC1);
    req = 4'b0001;
    tick(10);
    checks++;
    if (fire_cyc.size() != 2) begin
      errors++;
      $display("FAIL empty_fires: got %0d, want 2", fire_cyc.size());
    end
    checks++;
    if (rd_while_empty != 0) begin
      errors++;
      $display("FAIL empty_rd_guard: got %0d reads while empty, want 0", rd_while_empty);
    end
    checks++;
    if (rsp_q.size() != 2 || rsp_q[0] !== {4'b0001, 8'hC0} || rsp_q[1] !== {4'b0001, 8'hC1}) begin
      errors++;
      $display("FAIL empty_rsp: got count %0d, want 2 responses C0,C1 to requester 0", rsp_q.size());
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL empty_busy: got %b, want 0", busy);
    end
    req = '0;
  endtask

  task automatic test_req_drop();
    logic [11:0] exp;
    do_reset();
    for (int i = 0; i < 5; i++) push(8'h50 + 8'(i));
    req = 4'b1100;
    tick(2);        // IDLE decides, then the first fire to requester 2
    req = 4'b1000;  // requester 2 withdraws before its second beat
    tick(14);
    checks++;
    if (rsp_q.size() != 5) begin
      errors++;
      $display("FAIL drop_rsp_count: got %0d, want 5", rsp_q.size());
    end
    for (int i = 0; i < 5 && i < rsp_q.size(); i++) begin
      exp = {(i == 0) ? 4'b0100 : 4'b1000, 8'h50 + 8'(i)};
      checks++;
      if (rsp_q[i] !== exp) begin
        errors++;
        $display("FAIL drop_rsp%0d: got %h, want %h", i, rsp_q[i], exp);
      end
    end
    req = '0;
  endtask

  task automatic test_prio();
    logic [3:0] exp_gnt;
`ifdef FIFO_RD_ARB_PRIO_EN
    exp_gnt = 4'b0001;
`else
    exp_gnt = 4'b0010;
`endif
    do_reset();
    push(8'hE0);
    req = 4'b0001;   // a burst to requester 0 moves rr_ptr to 1 in pure round-robin
    tick(6);
    req = '0;
    clear_mon();
    push(8'hE1);
    push(8'hE2);
    req = 4'b0011;
    tick(1);
    checks++;
    if (gnt !== exp_gnt) begin
      errors++;
      $display("FAIL prio_first_grant: got %b, want %b", gnt, exp_gnt);
    end
    tick(8);
    checks++;
    if (rsp_q.size() < 1 || rsp_q[0] !== {exp_gnt, 8'hE1}) begin
      errors++;
      $display("FAIL prio_first_rsp: got %h, want %h",
               rsp_q.size() > 0 ? rsp_q[0] : 12'h0, {exp_gnt, 8'hE1});
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_rr_contention();
    test_empty_end();
    test_req_drop();
    test_prio();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
